// File: rtl/crossbar_rr_scheduler.sv
// rtl/crossbar_rr_scheduler.sv - round-robin crossbar path scheduler with burst-limited grants
module crossbar_rr_scheduler #(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int BURST_LEN         = 4,
  localparam int SW = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
  localparam int DW = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1,
  localparam int BW = $clog2(BURST_LEN + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_INPUTS-1:0]             req_val,
  input  logic [N_INPUTS-1:0][DW-1:0]     req_dest,
  output logic [N_INPUTS-1:0]             req_grant,
  output logic [CONTROL_BIT_WIDTH-1:0]    control,
  output logic                            control_val,
  input  logic                            control_rdy,
  input  logic                            xfer,
  output logic                            busy
);

  typedef enum logic [1:0] {IDLE, CONFIG, BUSY} state_t;

  state_t        state, state_next;
  logic [SW-1:0] rr_ptr, ptr_next;
  logic [SW-1:0] sel, sel_next;
  logic [DW-1:0] dest, dest_next;
  logic [BW-1:0] burst_cnt, cnt_next;
  logic [SW-1:0] pick, cand;
  logic          found;
  logic          rel_now;

  // First requester at or after rr_ptr, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      cand = SW'((int'(rr_ptr) + i) % N_INPUTS);
      if (!found && req_val[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    sel_next   = sel;
    dest_next  = dest;
    ptr_next   = rr_ptr;
    cnt_next   = burst_cnt;
    rel_now    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          sel_next   = pick;
          dest_next  = req_dest[pick];
          state_next = CONFIG;
        end
      end
      CONFIG: begin
        if (control_rdy) begin
          state_next = BUSY;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (xfer) cnt_next = burst_cnt + 1'b1;
        // Burst exhaustion and requester drop collapse into one release
        rel_now = (xfer && (burst_cnt == BW'(BURST_LEN - 1))) || !req_val[sel];
        if (rel_now) begin
          state_next = IDLE;
          ptr_next   = (sel == SW'(N_INPUTS - 1)) ? '0 : sel + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      dest      <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= ptr_next;
      sel       <= sel_next;
      dest      <= dest_next;
      burst_cnt <= cnt_next;
    end
  end

  always_comb begin
    req_grant = '0;
    if (state == BUSY) req_grant[sel] = 1'b1;
  end

  assign control     = {sel, dest, {(CONTROL_BIT_WIDTH - SW - DW){1'b0}}};
  assign control_val = (state == CONFIG);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// tb/tb_crossbar_rr_scheduler.sv - directed and randomized checks of crossbar_rr_scheduler against a transaction model
module tb_crossbar_rr_scheduler;
  localparam int N  = 2;
  localparam int NO = 2;
  localparam int CW = 42;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_val;
  logic [N-1:0][0:0] req_dest;
  logic [N-1:0]      req_grant;
  logic [CW-1:0]     control;
  logic              control_val;
  logic              control_rdy;
  logic              xfer;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: who owns the path, whether its config was accepted, messages sent
  int m_owner, m_ptr, m_sel, m_dest, m_sent;
  bit m_cfgd;

  crossbar_rr_scheduler #(
    .N_INPUTS(N), .N_OUTPUTS(NO), .CONTROL_BIT_WIDTH(CW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_dest(req_dest),
    .req_grant(req_grant), .control(control), .control_val(control_val),
    .control_rdy(control_rdy), .xfer(xfer), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_dest = 0; m_sent = 0; m_cfgd = 1'b0;
  endtask

  task automatic model_advance();
    bit done;
    if (reset) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && req_val[c]) begin
          m_owner = c; m_sel = c; m_dest = int'(req_dest[c]); m_cfgd = 1'b0;
        end
      end
    end else if (!m_cfgd) begin
      if (control_rdy) begin m_cfgd = 1'b1; m_sent = 0; end
    end else begin
      done = (xfer && (m_sent + 1 == BL)) || !req_val[m_owner];
      if (xfer) m_sent++;
      if (done) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [CW-1:0] ec;
    logic [N-1:0]  eg;
    ec = '0;
    ec = ec | (CW'(m_sel) << (CW - 1)) | (CW'(m_dest) << (CW - 2));
    eg = '0;
    if (m_owner >= 0 && m_cfgd) eg = N'(1) << m_owner;
    chk({tag, "/busy"},  64'(busy),        64'(m_owner >= 0));
    chk({tag, "/cval"},  64'(control_val), 64'(m_owner >= 0 && !m_cfgd));
    chk({tag, "/grant"}, 64'(req_grant),   64'(eg));
    chk({tag, "/ctrl"},  64'(control),     64'(ec));
  endtask

  task automatic step(input string tag);
    check_outputs(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] v, input logic [1:0] d, input logic rdy, input logic x);
    req_val = v; req_dest = d; control_rdy = rdy; xfer = x;
  endtask

  initial begin
    int owners[$];
    int lens[$];
    int gaps[$];
    bit in_grant;
    int glen, idle_run;
    logic [CW-1:0] word0;

    reset = 1'b1;
    set_in(2'b00, 2'b00, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    step("rst");
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ctrl", 64'(control), 64'(0));
    reset = 1'b0;

    // Single request from input 1 to output 1
    set_in(2'b10, 2'b10, 1'b1, 1'b0);
    step("single_t");
    chk("single_cval", 64'(control_val), 64'(1));
    chk("single_top", 64'(control[CW-1 -: 2]), 64'(2'b11));
    chk("single_nogrant", 64'(req_grant), 64'(0));
    step("single_t1");
    chk("single_grant", 64'(req_grant), 64'(2'b10));
    set_in(2'b00, 2'b00, 1'b1, 1'b0);
    step("single_rel");
    step("single_idle");

    // Both inputs request continuously with xfer every cycle
    set_in(2'b11, 2'b01, 1'b1, 1'b1);
    in_grant = 1'b0; glen = 0; idle_run = 0;
    for (int c = 0; c < 40; c++) begin
      step("fair");
      if (req_grant != '0 && !in_grant) begin
        owners.push_back(req_grant[1] ? 1 : 0);
        in_grant = 1'b1; glen = 0;
      end
      if (in_grant) begin
        if (req_grant != '0) glen++;
        else begin lens.push_back(glen); in_grant = 1'b0; end
      end
      if (!busy) idle_run++;
      else if (idle_run > 0) begin gaps.push_back(idle_run); idle_run = 0; end
    end
    chk("fair_count", 64'(owners.size() >= 4), 64'(1));
    for (int i = 0; i < 4; i++)
      if (i < owners.size()) chk("fair_owner", 64'(owners[i]), 64'(i % 2));
    for (int i = 0; i < 3; i++) begin
      if (i < lens.size()) chk("burst_len", 64'(lens[i]), 64'(BL));
      if (i < gaps.size()) chk("idle_gap", 64'(gaps[i]), 64'(1));
    end
    set_in(2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("drain");

    // Control backpressure for three cycles
    set_in(2'b01, 2'b01, 1'b0, 1'b0);
    step("bp_req");
    word0 = control;
    chk("bp_word", 64'(word0), 64'(1) << (CW - 2));
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      chk("bp_cval", 64'(control_val), 64'(1));
      chk("bp_const", 64'(control), 64'(word0));
      chk("bp_nogrant", 64'(req_grant), 64'(0));
    end
    control_rdy = 1'b1;
    step("bp_rdy");
    chk("bp_grant", 64'(req_grant), 64'(2'b01));

    // Early drop after one message, then simultaneous last xfer and drop
    set_in(2'b11, 2'b00, 1'b1, 1'b1);
    step("drop_x1");
    set_in(2'b10, 2'b00, 1'b1, 1'b0);
    step("drop_rel");
    chk("drop_idle", 64'(busy), 64'(0));
    set_in(2'b11, 2'b00, 1'b1, 1'b0);
    step("drop_arb");
    chk("drop_ptr", 64'(control[CW-1]), 64'(1));
    step("drop_cfg");
    chk("drop_grant1", 64'(req_grant), 64'(2'b10));
    xfer = 1'b1;
    for (int i = 0; i < 3; i++) step("simul_x");
    set_in(2'b01, 2'b00, 1'b1, 1'b1);
    step("simul_rel");
    chk("simul_idle", 64'(busy), 64'(0));
    set_in(2'b11, 2'b00, 1'b1, 1'b0);
    step("simul_arb");
    chk("simul_ptr", 64'(control[CW-1]), 64'(0));
    step("simul_cfg");

    // Reset while input 1 is mid-burst
    set_in(2'b10, 2'b00, 1'b1, 1'b0);
    step("rb_rel");
    set_in(2'b11, 2'b11, 1'b1, 1'b0);
    step("rb_arb");
    step("rb_cfg");
    chk("rb_grant", 64'(req_grant), 64'(2'b10));
    xfer = 1'b1;
    step("rb_x1");
    step("rb_x2");
    reset = 1'b1; xfer = 1'b0;
    step("rb_reset");
    chk("rb_zero_grant", 64'(req_grant), 64'(0));
    chk("rb_zero_ctrl", 64'(control), 64'(0));
    chk("rb_zero_cval", 64'(control_val), 64'(0));
    chk("rb_zero_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    step("rb_arb2");
    chk("rb_ptr0", 64'(control[CW-1]), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) req_val[i] = ~req_val[i];
      req_dest    = 2'($urandom_range(0, 3));
      control_rdy = ($urandom_range(0, 3) != 0);
      xfer        = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/crossbar_rr_scheduler.md
CROSSBAR_RR_SCHEDULER -- requirements
Module: crossbar_rr_scheduler

Interface
Parameters:
REQ-001 The block SHALL have parameter N_INPUTS, default 2, meaning the number of crossbar input ports (requesters).
REQ-002 The block SHALL have parameter N_OUTPUTS, default 2, meaning the number of crossbar output ports.
REQ-003 The block SHALL have parameter CONTROL_BIT_WIDTH, default 42, meaning the width of the crossbar control word.
REQ-004 The block SHALL have parameter BURST_LEN, default 4, meaning the maximum number of messages transferred per grant; BURST_LEN >= 1.

Ports:
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req_val, input, [N_INPUTS] x 1: input i has a message pending.
REQ-008 The block SHALL have port req_dest, input, [N_INPUTS] x $clog2(N_OUTPUTS): destination output for input i; valid while req_val[i]=1.
REQ-009 The block SHALL have port req_grant, output, [N_INPUTS] x 1: one-hot or zero; input i currently owns the crossbar path.
REQ-010 The block SHALL have port control, output, CONTROL_BIT_WIDTH: configuration word to the crossbar.
REQ-011 The block SHALL have port control_val, output, 1: control word valid.
REQ-012 The block SHALL have port control_rdy, input, 1: crossbar accepts the control word.
REQ-013 The block SHALL have port xfer, input, 1: pulses for one cycle per message accepted at the granted output (send_val & send_rdy of that output).
REQ-014 The block SHALL have port busy, output, 1: the scheduler is in CONFIG or BUSY.

Function
REQ-015 The block SHALL implement three states, IDLE, CONFIG and BUSY; busy=1 in CONFIG and in BUSY.
REQ-016 In IDLE, if any req_val is 1, the block SHALL select the first requesting index at or after rr_ptr (round-robin, wrapping past N_INPUTS-1 to 0), latch sel and dest=req_dest[sel], and enter CONFIG next cycle.
REQ-017 control SHALL be formed as: bits [CW-1 : CW-$clog2(N_INPUTS)] = sel; the next $clog2(N_OUTPUTS) bits below = dest; all remaining low bits = 0.
REQ-018 In CONFIG, control_val SHALL be 1 and control SHALL stay constant until control_val & control_rdy; on that cycle the state SHALL go to BUSY and burst_cnt SHALL clear to 0.
REQ-019 control_val SHALL be 0 in IDLE and in BUSY.
REQ-020 req_grant[sel] SHALL be 1 only in BUSY; all other grant bits SHALL be 0 at all times.
REQ-021 Latency: with req_val first seen in cycle t and control_rdy=1, control_val=1 in t+1 and req_grant=1 in t+2.
REQ-022 In BUSY, each cycle with xfer=1 SHALL increment burst_cnt; xfer SHALL be ignored in IDLE and CONFIG.
REQ-023 The block SHALL release from BUSY to IDLE on xfer=1 with burst_cnt=BURST_LEN-1, or when req_val[sel]=0; release on simultaneous occurrence of both SHALL be a single release.
REQ-024 On release, rr_ptr SHALL be set to (sel+1) mod N_INPUTS, and the grant SHALL drop in the following cycle.
REQ-025 From IDLE after release, a new request SHALL be arbitrated in the same cycle as the IDLE entry, giving one idle cycle minimum between grants.
REQ-026 Changes to req_val or req_dest of non-selected inputs during CONFIG/BUSY SHALL have no effect; dest SHALL hold latched.
REQ-027 A requester dropping req_val[sel] during CONFIG SHALL NOT abort CONFIG; release SHALL occur in the first BUSY cycle.

Reset
REQ-028 While reset=1, the block SHALL set the state to IDLE, rr_ptr to 0, sel, dest and burst_cnt to 0, and req_grant, control_val and busy to 0, with control = 0.
REQ-029 Reset asserted mid-CONFIG or mid-BUSY SHALL abandon the grant immediately at the next edge, without pointer advance.

Verification
REQ-030 Single request: N_INPUTS=2, req_val={0,1}, req_dest[1]=1, control_rdy=1 -> control_val in t+1 with top bits sel=1, dest=1; req_grant[1] in t+2.
REQ-031 Burst limit: BURST_LEN=4, hold req_val, 4 xfer pulses -> grant drops after the 4th; busy=0 for one cycle, then re-grant.
REQ-032 Fairness: both inputs request continuously -> grants alternate 0,1,0,1 starting from input 0 after reset.
REQ-033 Backpressure: control_rdy=0 for 3 cycles -> control_val held 1 with a constant word; no grant until the rdy cycle.
REQ-034 Early drop: req_val[sel] falls after 1 xfer -> release, rr_ptr=sel+1; a simultaneous last xfer plus drop -> exactly one release.
REQ-035 Reset in BUSY: assert reset with burst_cnt=2 -> next cycle all outputs 0 and rr_ptr=0.
